// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a valid/ready write port feeds a FIFO that drains into
// an 8N1-style serializer with optional parity and one or two stop bits.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DEPTH      = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic                     tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(DEPTH);
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CNT_W    = $clog2(STOP_LEN);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [AW:0]      FULL      = (AW+1)'(DEPTH);
  localparam logic             PAR_EN    = (PARITY_EN != 0);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [7:0]       shift_reg, shift_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_idx, bit_next;
  logic             tx_next, busy_next;
  logic             push, pop;

  assign wr_ready   = (count != FULL);
  assign push       = wr_valid && wr_ready;
  assign fifo_count = count;

  // Storage is not reset; reset only empties the queue via the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
      tx_busy   <= busy_next;
    end
  end

  // tx is only ever loaded on a bit boundary, so the line is glitch-free.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    tx_next    = tx;
    busy_next  = tx_busy;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            if (PAR_EN) begin
              tx_next    = (^shift_reg) ^ PAR_ODD;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_next = bit_idx + 3'd1;
            tx_next  = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        // A queued byte starts its start bit right as the stop period ends.
        if (baud_cnt == STOP_LAST) begin
          baud_next = '0;
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: one 8N1 instance plus even/odd parity
// instances with two stop bits, all at 10 clocks per bit.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid0, wr_valid_p;
  logic       wr_ready0, wr_ready1, wr_ready2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic [4:0] count0, count1, count2;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int stop_err = 0;
  int max_cnt = 0;
  int run_len[3];
  int last_run[3];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100)) u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid0), .wr_data(wr_data),
    .wr_ready(wr_ready0), .tx(tx0), .tx_busy(busy0), .fifo_count(count0));

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_even (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_p), .wr_data(wr_data),
    .wr_ready(wr_ready1), .tx(tx1), .tx_busy(busy1), .fifo_count(count1));

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_p), .wr_data(wr_data),
    .wr_ready(wr_ready2), .tx(tx2), .tx_busy(busy2), .fifo_count(count2));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Host-side write: holds valid until the block is ready, then one accept edge.
  task automatic applyStimulus(input logic [7:0] b);
    int t = 0;
    wr_data   = b;
    wr_valid0 = 1'b1;
    while (wr_ready0 !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("wr_accept_wait", wr_ready0, 1);
    @(negedge clk);
    wr_valid0 = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic waitIdle(input int limit);
    int t = 0;
    while ((busy0 !== 1'b0 || count0 !== 5'd0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    checkOutput("idle_wait", busy0, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic checkStream(input string tag);
    checkOutput({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i),
                  (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    checkOutput({tag, "_stop"}, stop_err, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Line decoder for the 8N1 instance: samples mid-bit, five clocks into each bit.
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (!reset && tx0 === 1'b0) begin
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        b[i] = tx0;
      end
      repeat (10) @(negedge clk);
      if (tx0 !== 1'b1) stop_err++;
      rx_q.push_back(b);
    end
  end

  always @(negedge clk) begin
    logic [2:0] bv;
    bv = {busy2, busy1, busy0};
    if (int'(count0) > max_cnt) max_cnt = int'(count0);
    for (int i = 0; i < 3; i++) begin
      if (reset) run_len[i] = 0;
      else if (bv[i]) run_len[i]++;
      else begin
        if (run_len[i] != 0) last_run[i] = run_len[i];
        run_len[i] = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0]  a5_line;
    logic [11:0] even_line, odd_line;
    int lows;
    a5_line   = 10'b1101001010;
    even_line = 12'b111000001110;
    odd_line  = 12'b110000001110;
    for (int i = 0; i < 3; i++) begin
      run_len[i]  = 0;
      last_run[i] = 0;
    end
    reset = 1'b1;
    wr_valid0 = 1'b0;
    wr_valid_p = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx0, 1);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_count", count0, 0);
    checkOutput("rst_ready", wr_ready0, 1);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5);
    checkOutput("lat_count_k", count0, 1);
    checkOutput("lat_tx_k", tx0, 1);
    @(negedge clk);
    checkOutput("lat_tx_k1", tx0, 0);
    checkOutput("lat_count_k1", count0, 0);
    checkOutput("lat_busy_k1", busy0, 1);
    repeat (4) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      checkOutput($sformatf("a5_line%0d", j), tx0, a5_line[j]);
      repeat (10) @(negedge clk);
    end
    waitIdle(300);
    checkOutput("a5_busy_len", last_run[0], 100);
    checkStream("a5");

    $display("[TB] burst and full-FIFO hold");
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
    checkOutput("burst_count", count0, 15);
    checkOutput("burst_ready", wr_ready0, 1);
    applyStimulus(8'h11);
    checkOutput("full_count", count0, 16);
    checkOutput("full_ready", wr_ready0, 0);
    wr_data = 8'hFF;
    wr_valid0 = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("hold_count", count0, 16);
    checkOutput("hold_ready", wr_ready0, 0);
    lows = 0;
    while (wr_ready0 !== 1'b1 && lows < 200) begin
      @(negedge clk);
      lows++;
    end
    checkOutput("pop_frees_slot", count0, 15);
    applyStimulus(8'hFF);
    checkOutput("refill_count", count0, 16);
    waitIdle(2500);
    checkOutput("burst_final_count", count0, 0);
    checkOutput("burst_final_busy", busy0, 0);
    checkOutput("burst_busy_len", last_run[0], 1800);
    checkOutput("burst_max_count", max_cnt, 16);
    checkStream("burst");

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 6; i++) applyStimulus(8'h21 + 8'(i));
    repeat (40) @(negedge clk);
    checkOutput("pre_rst_tx_bit3", tx0, 0);
    checkOutput("pre_rst_count", count0, 5);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_tx", tx0, 1);
    checkOutput("mid_rst_busy", busy0, 0);
    checkOutput("mid_rst_count", count0, 0);
    checkOutput("mid_rst_ready", wr_ready0, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) lows++;
    end
    checkOutput("idle_after_rst", lows, 0);
    rx_q.delete();
    exp_q.delete();
    stop_err = 0;
    applyStimulus(8'h3C);
    waitIdle(300);
    checkStream("post_rst");

    $display("[TB] parity with two stop bits");
    @(negedge clk);
    wr_data = 8'h07;
    wr_valid_p = 1'b1;
    checkOutput("par_even_ready", wr_ready1, 1);
    checkOutput("par_odd_ready", wr_ready2, 1);
    @(negedge clk);
    wr_valid_p = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      checkOutput($sformatf("even_line%0d", j), tx1, even_line[j]);
      checkOutput($sformatf("odd_line%0d", j), tx2, odd_line[j]);
      repeat (10) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checkOutput("even_busy_len", last_run[1], 120);
    checkOutput("odd_busy_len", last_run[2], 120);

    $display("[TB] random-gap stream");
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(8'($urandom));
    end
    waitIdle(5000);
    checkOutput("stream_max_le_depth", (max_cnt <= 16) ? 1 : 0, 1);
    checkStream("stream");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered UART transmitter. A host pushes bytes through a valid/ready write port into an internal FIFO, and the block serializes them onto tx as 8-bit frames. Frames go LSB first, with optional parity and 1 or 2 stop bits. It is the transmit-side counterpart to the team's UART receiver-plus-FIFO path, so producers can burst data without polling tx_busy.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer division, must be >= 2)
DEPTH, 16, FIFO entries; power of two, >= 2
PARITY_EN, 0, 1 = append a parity bit after data bit 7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
wr_valid  input  1  host presents wr_data
wr_data  input  8  byte to transmit
wr_ready  output  1  FIFO can accept; a write occurs on an edge where wr_valid && wr_ready
tx  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line, registered
fifo_count  output  $clog2(DEPTH)+1  bytes currently queued (excluding the frame in flight)

Behaviour:
- Reset (async, any time including mid-frame): tx=1, tx_busy=0, fifo_count=0, wr_ready=1, state=IDLE, pointers and baud/bit counters=0. FIFO contents are discarded, and the partial frame is abandoned with the line immediately high.
- wr_ready = (fifo_count != DEPTH), decoded from the registered count. A write while wr_ready=0 is ignored; wr_data is not stored and the count does not change.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- On the same edge, a push and a pop give count unchanged, both pointers advance, and the popped entry is the old head.
- FSM states:
  - IDLE: if fifo_count != 0, pop the head into shift_reg, drive tx<=0, tx_busy<=1, clear the baud counter, go to START. Otherwise tx=1, tx_busy=0.
  - START: after BAUD_DIV cycles, go to DATA with bit index 0 and tx<=shift_reg[0].
  - DATA: each bit is held BAUD_DIV cycles. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = ^data XOR PARITY_ODD, held BAUD_DIV cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV cycles. At the end:
    - If fifo_count != 0, pop the next byte and start its start bit on that same edge (back-to-back, no idle gap; tx_busy stays 1).
    - Otherwise go to IDLE with tx_busy<=0.
- Every line bit lasts exactly BAUD_DIV clocks. Frame length = BAUD_DIV*(1+8+PARITY_EN+STOP_BITS) clocks.
- Latency: a write accepted at edge k into an empty, idle block gives tx falling at edge k+1 and fifo_count back to 0 at edge k+1.
- The popped byte is held in shift_reg. FIFO writes never corrupt the frame in flight.
- tx has no glitches: it changes only on bit boundaries, from a register.

Test Plan:
- Set CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10), defaults otherwise. Write 0xA5 once → tx low one cycle after accept, then line sequence 0,1,0,1,0,0,1,0,1,1 with each bit 10 clocks; tx_busy high for exactly 100 clocks.
- Burst-write 0x01..0x10 (16 bytes) while idle → wr_ready drops when count reaches 16 after the first pop; 16 frames back-to-back with no idle cycle between stop bit and next start; final fifo_count=0, tx_busy=0.
- Fill the FIFO to DEPTH, hold wr_valid=1 with 0xFF → nothing is accepted until a pop. On a pop edge a push is accepted, count stays DEPTH-1→DEPTH correctly, and there is no overwrite (received byte order unchanged).
- Set PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07 → parity bit 1 and two 10-clock stop bits (120-clock frame). Repeat with PARITY_ODD=1 → parity bit 0.
- Assert reset during data bit 3 with 5 bytes queued → tx=1, tx_busy=0, fifo_count=0 immediately. After release the line stays idle, and a new write of 0x3C transmits correctly.
- Pointer wrap: stream 40 bytes at random valid gaps → transmitted sequence is identical to the written sequence and fifo_count never exceeds 16.
